soc_system_endstop_ctrl: RTL

SOC_SYSTEM_ENDSTOP_CTRL -- requirements
Module: soc_system_endstop_ctrl

---
 rtl/soc_system_endstop_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/soc_system_endstop_ctrl.sv
// Purpose : debounced endstop switch monitor with per-axis halt latch, edge interrupt and Avalon-MM CSRs.
// Latency : input to stable = 2 sync edges + DEBOUNCE_CYCLES; readdata 1 cycle after address.
// Backpr. : none; the slave is always ready, and reads and writes complete without wait states.
//
// Ports   : clk, reset (async, active-high)
//           address[1:0], write, writedata[31:0], readdata[31:0]   Avalon-MM slave
//           in_port[5:0]   raw switch inputs (asynchronous)
//           axis_stop[5:0] latched halt request per axis
//           irq            level interrupt = |(edge & irq_mask)
// Macro   : ENDSTOP_CTRL_DEBOUNCE_EN enables the per-channel debounce counters. When the
//           macro is undefined, stable follows sync every cycle and DEBOUNCE_CYCLES is ignored.
// Map     : 0 RO {sync[13:8], level[5:0]}   1 RW polarity[5:0]
//           2 RW {arm[13:8], irq_mask[5:0]} 3 W1C {trip[13:8], edge[5:0]}
module soc_system_endstop_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [5:0]  in_port,
  output logic [5:0]  axis_stop,
  output logic        irq
);

  logic [5:0]  sync_meta;
  logic [5:0]  sync;
  logic [5:0]  stable;
  logic [5:0]  stable_nxt;
  logic [5:0]  polarity;
  logic [5:0]  irq_mask;
  logic [5:0]  arm;
  logic [5:0]  edge_flag;
  logic [5:0]  trip_flag;
  logic [5:0]  level;
  logic [5:0]  edge_set;
  logic [5:0]  edge_clr;
  logic [5:0]  trip_clr;
  logic [31:0] rd_nxt;
  logic        unused_wd;

  assign unused_wd = ^{writedata[31:14], writedata[7:6]};

`ifdef ENDSTOP_CTRL_DEBOUNCE_EN
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [5:0][15:0] cnt;
  logic [5:0][15:0] cnt_nxt;

  // A channel must disagree with stable for DEBOUNCE_CYCLES consecutive
  // cycles. Any agreement in between restarts the count from zero.
  always_comb begin
    stable_nxt = stable;
    cnt_nxt    = cnt;
    for (int i = 0; i < 6; i++) begin
      if (sync[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_nxt[i] = sync[i];
          cnt_nxt[i]    = '0;
        end else begin
          cnt_nxt[i] = cnt[i] + 16'd1;
        end
      end else begin
        cnt_nxt[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end
`else
  logic [15:0] unused_cfg;
  assign unused_cfg = 16'(DEBOUNCE_CYCLES);
  assign stable_nxt = sync;
`endif

  assign level = stable ^ polarity;

  // Edges are taken from the stable transition itself. A polarity change
  // alone flips level without moving stable, so it never raises an edge.
  assign edge_set = (stable_nxt ^ stable) & (stable_nxt ^ polarity);

  assign edge_clr = (write && address == 2'd3) ? writedata[5:0]  : 6'd0;
  assign trip_clr = (write && address == 2'd3) ? writedata[13:8] : 6'd0;

  always_comb begin
    rd_nxt = '0;
    case (address)
      2'd0:    rd_nxt = {18'd0, sync, 2'd0, level};
      2'd1:    rd_nxt = {26'd0, polarity};
      2'd2:    rd_nxt = {18'd0, arm, 2'd0, irq_mask};
      default: rd_nxt = {18'd0, trip_flag, 2'd0, edge_flag};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync      <= '0;
      stable    <= '0;
      polarity  <= '0;
      irq_mask  <= '0;
      arm       <= '0;
      edge_flag <= '0;
      trip_flag <= '0;
      readdata  <= '0;
    end else begin
      sync_meta <= in_port;
      sync      <= sync_meta;
      stable    <= stable_nxt;
      if (write && address == 2'd1) begin
        polarity <= writedata[5:0];
      end
      if (write && address == 2'd2) begin
        arm      <= writedata[13:8];
        irq_mask <= writedata[5:0];
      end
      // Set wins over a same-cycle clear, so no event is lost. A trip on
      // an armed, active channel therefore persists until it is disarmed.
      edge_flag <= (edge_flag & ~edge_clr) | edge_set;
      trip_flag <= (trip_flag & ~trip_clr) | (arm & level);
      readdata  <= rd_nxt;
    end
  end

  assign axis_stop = trip_flag;
  assign irq       = |(edge_flag & irq_mask);

endmodule
